// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types and constants for the MIPS data-memory load/store path.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and memory bus signals of the load/store initiator.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module lsu_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: strobes, store replication,
// req/ack handshake with timeout, and aligned load return.
module lsu_mem_initiator
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  lsu_mem_initiator_if.master bus
);

  lsu_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic        r_mem_req;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  mem_size_t   r_size;
  logic [1:0]  r_lane;
  logic        r_uns;

  mem_size_t   w_size;
  logic        w_hs;
  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_size = mem_size_t'(bus.req_size);
  assign w_hs   = bus.req_valid && (r_state == IDLE);
  assign w_bad  = (w_size == SZ_BAD) ||
                  ((w_size == SZ_HALF) && bus.req_addr[0]) ||
                  ((w_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    w_be    = BE_WORD;
    w_wdata = bus.req_wdata;
    case (w_size)
      SZ_BYTE: begin
        w_be    = BE_BYTE << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = BE_HALF << {bus.req_addr[1], 1'b0};
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .i_rdata    (bus.mem_rdata),
    .i_addr     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 4'h0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
      r_size    <= SZ_BYTE;
      r_lane    <= 2'b00;
      r_uns     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_size  <= w_size;
          r_lane  <= bus.req_addr[1:0];
          r_uns   <= bus.req_unsigned;
          r_rdata <= 32'h0;
          // Bad requests never reach the bus; mem_* outputs keep old values.
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_err     <= 1'b0;
            r_mem_req <= 1'b1;
            r_we      <= bus.req_we;
            r_be      <= w_be;
            r_addr    <= {bus.req_addr[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_cnt     <= '0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          // Ack takes priority over a simultaneous timeout.
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= r_we ? 32'h0 : w_load;
            r_state   <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= 32'h0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: if (bus.resp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_we;
  assign bus.mem_be     = r_be;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: stores, loads, alignment errors,
// timeout, response back-pressure and asynchronous reset.
module tb_lsu_mem_initiator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n;

  lsu_mem_initiator_if bus();

  lsu_mem_initiator #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns just after the handshake edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ack = 1'b0;
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    reset_n = 1'b1;
    step();

    // sw 0x10
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_mem_req", 32'(bus.mem_req), 32'd1);
    chk("sw_req_ready", 32'(bus.req_ready), 32'd0);
    chk("sw_mem_we", 32'(bus.mem_we), 32'd1);
    chk("sw_mem_addr", bus.mem_addr, 32'h10);
    chk("sw_mem_be", 32'(bus.mem_be), 32'hF);
    chk("sw_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    ack(32'h55555555);
    chk("sw_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("sw_mem_req_drop", 32'(bus.mem_req), 32'd0);
    chk("sw_resp_err", 32'(bus.resp_err), 32'd0);
    chk("sw_resp_rdata", bus.resp_rdata, 32'd0);
    release_resp();
    chk("sw_back_idle", 32'(bus.req_ready), 32'd1);

    // sb 0x13
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    chk("sb_mem_be", 32'(bus.mem_be), 32'h8);
    chk("sb_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    chk("sb_mem_addr", bus.mem_addr, 32'h10);
    ack(32'h0);
    release_resp();

    // sh 0x22: upper half lanes
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    chk("sh_mem_be", 32'(bus.mem_be), 32'hC);
    chk("sh_mem_wdata", bus.mem_wdata, 32'hBEEFBEEF);
    ack(32'h0);
    release_resp();

    // lb / lbu 0x21, lh 0x22
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    chk("lb_mem_we", 32'(bus.mem_we), 32'd0);
    chk("lb_mem_be", 32'(bus.mem_be), 32'h2);
    chk("lb_mem_addr", bus.mem_addr, 32'h20);
    ack(32'h12348056);
    chk("lb_rdata", bus.resp_rdata, 32'hFFFFFF80);
    chk("lb_err", 32'(bus.resp_err), 32'd0);
    release_resp();
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    ack(32'h12348056);
    chk("lbu_rdata", bus.resp_rdata, 32'h00000080);
    release_resp();
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    ack(32'h12348056);
    chk("lh_rdata", bus.resp_rdata, 32'h00001234);
    release_resp();
    issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    ack(32'h12348056);
    chk("lhu_rdata", bus.resp_rdata, 32'h00008056);
    release_resp();

    // misaligned half and illegal size
    issue(1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
    chk("mis_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("mis_resp_err", 32'(bus.resp_err), 32'd1);
    chk("mis_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mis_rdata", bus.resp_rdata, 32'd0);
    release_resp();
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    chk("bad_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("bad_resp_err", 32'(bus.resp_err), 32'd1);
    chk("bad_mem_req", 32'(bus.mem_req), 32'd0);
    chk("bad_rdata", bus.resp_rdata, 32'd0);
    release_resp();

    // timeout: count mem_req cycles
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_resp_err", 32'(bus.resp_err), 32'd1);
    chk("to_rdata", bus.resp_rdata, 32'd0);
    release_resp();
    ack(32'hFFFFFFFF);
    chk("late_ack_valid", 32'(bus.resp_valid), 32'd0);
    chk("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
    chk("late_ack_ready", 32'(bus.req_ready), 32'd1);

    // ack in the final timeout cycle wins
    issue(1'b0, 2'b10, 1'b1, 32'h44, 32'h0);
    for (int i = 0; i < 15; i++) step();
    chk("edge_mem_req", 32'(bus.mem_req), 32'd1);
    ack(32'hCAFEF00D);
    chk("edge_err", 32'(bus.resp_err), 32'd0);
    chk("edge_rdata", bus.resp_rdata, 32'hCAFEF00D);

    // back-pressure: response held 5 cycles, stray ack ignored
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack   = (i == 2);
      bus.mem_rdata = 32'h11111111 * i;
      step();
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_resp_rdata", bus.resp_rdata, 32'hCAFEF00D);
    end
    bus.mem_ack = 1'b0;
    release_resp();

    // asynchronous reset mid-BUSY
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    chk("rb_mem_req", 32'(bus.mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_mem_req", 32'(bus.mem_req), 32'd0);
    chk("ar_mem_addr", bus.mem_addr, 32'd0);
    chk("ar_mem_be", 32'(bus.mem_be), 32'd0);
    chk("ar_mem_wdata", bus.mem_wdata, 32'd0);
    chk("ar_mem_we", 32'(bus.mem_we), 32'd0);
    chk("ar_resp_valid", 32'(bus.resp_valid), 32'd0);
    step();
    reset_n = 1'b1;
    ack(32'h0);
    chk("ar_ready_after", 32'(bus.req_ready), 32'd1);
    chk("ar_no_resp", 32'(bus.resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
